pcm_pingpong_buffer: RTL and testbench

Ping-pong (double-bank) sample buffer sitting between the audio PCM receiver and the VU-meter consumer. It fills one bank of DEPTH 24-bit samples from a non-backpressurable sample strobe while the other bank is streamed out over a ready/valid interface. A one-cycle buffer-ready pulse announces each full bank to the consumer. Samples that arrive while both banks are occupied are dropped and flagged.

---
 rtl/pcm_pingpong_buffer.sv | 143 ++++++++++++++
 tb/tb_pcm_pingpong_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pcm_pingpong_buffer.sv
// pcm_pingpong_buffer: double-bank PCM sample buffer between the PCM receiver and the VU-meter
// consumer. One bank fills from a non-backpressurable strobe while the other streams out over
// ready/valid. A one-cycle pulse announces each full bank. Samples arriving while both banks are
// occupied are dropped and flagged on a sticky overflow bit.
// Optional: define OVERFLOW_CNT_EN to add a saturating 16-bit drop counter (overflow_count_o).
module pcm_pingpong_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_W-1:0]      sample_i,
  input  logic                   sample_valid_i,
  output logic [DATA_W-1:0]      ram_read_data_o,
  output logic                   ram_read_valid_o,
  input  logic                   ram_read_ready_i,
  output logic                   ram_buffer_ready_o,
  output logic [$clog2(DEPTH):0] fill_level_o,
  output logic                   overflow_o,
`ifdef OVERFLOW_CNT_EN
  output logic [15:0]            overflow_count_o,
`endif
  input  logic                   clear_overflow_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {RdIdle, RdAnnounce, RdStream} rd_state_e;

  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_bank_q, rd_bank_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [1:0]        bank_full_q;
  rd_state_e         rd_state_q;
  logic              overflow_q;
  logic              wr_en, wr_drop, wr_last;
  logic              rd_fire, rd_last, rd_start, rd_en;
  logic [PtrW:0]     rd_addr;

  // Handshake decode shared by the write side, the bank flags and the read FSM
  always_comb begin
    wr_en      = sample_valid_i && !bank_full_q[wr_bank_q];
    wr_drop    = sample_valid_i && bank_full_q[wr_bank_q];
    wr_last    = wr_en && (wr_ptr_q == PtrW'(DEPTH - 1));
    rd_fire    = (rd_state_q == RdStream) && ram_read_ready_i;
    rd_last    = rd_fire && (rd_ptr_q == PtrW'(DEPTH - 1));
    // Look ahead at a bank completing this cycle so the pulse lands one cycle after the last write
    rd_start   = (rd_state_q == RdIdle) &&
                 (bank_full_q[rd_bank_q] || (wr_last && (wr_bank_q == rd_bank_q)));
    rd_ptr_nxt = rd_ptr_q + PtrW'(1);
    rd_en      = (rd_state_q == RdAnnounce) || (rd_fire && !rd_last);
    rd_addr    = (rd_state_q == RdAnnounce) ? {rd_bank_q, PtrW'(0)} : {rd_bank_q, rd_ptr_nxt};
  end

  // Sample storage write port (contents are deliberately not reset)
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[{wr_bank_q, wr_ptr_q}] <= sample_i;
  end

  // Synchronous read port; only advances on a fetch so data holds under backpressure
  always_ff @(posedge clk_i) begin
    if (rst_i)      rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  // Write pointer, write bank and sticky overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      wr_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_last) begin
        wr_ptr_q  <= '0;
        wr_bank_q <= ~wr_bank_q;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      // A drop in the same cycle as a clear keeps the flag set
      if (wr_drop)               overflow_q <= 1'b1;
      else if (clear_overflow_i) overflow_q <= 1'b0;
    end
  end

`ifdef OVERFLOW_CNT_EN
  logic [15:0] overflow_cnt_q;

  // Saturating drop counter; clear plus drop in one cycle leaves exactly one
  always_ff @(posedge clk_i) begin
    if (rst_i)                          overflow_cnt_q <= '0;
    else if (clear_overflow_i)          overflow_cnt_q <= wr_drop ? 16'd1 : 16'd0;
    else if (wr_drop && (overflow_cnt_q != 16'hFFFF)) overflow_cnt_q <= overflow_cnt_q + 16'd1;
  end

  assign overflow_count_o = overflow_cnt_q;
`endif

  // Bank ownership: set by the writer on the last sample, cleared by the reader on release
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_full_q <= 2'b00;
    end else begin
      if (wr_last) bank_full_q[wr_bank_q] <= 1'b1;
      if (rd_last) bank_full_q[rd_bank_q] <= 1'b0;
    end
  end

  // Read FSM: announce a full bank for one cycle, then stream it without bubbles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= RdIdle;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
    end else begin
      case (rd_state_q)
        RdIdle: begin
          if (rd_start) rd_state_q <= RdAnnounce;
        end
        RdAnnounce: begin
          rd_ptr_q   <= '0;
          rd_state_q <= RdStream;
        end
        RdStream: begin
          if (rd_last) begin
            rd_bank_q  <= ~rd_bank_q;
            rd_state_q <= RdIdle;
          end else if (rd_fire) begin
            rd_ptr_q <= rd_ptr_nxt;
          end
        end
        default: rd_state_q <= RdIdle;
      endcase
    end
  end

  assign ram_read_data_o    = rd_data_q;
  assign ram_read_valid_o   = (rd_state_q == RdStream);
  assign ram_buffer_ready_o = (rd_state_q == RdAnnounce);
  assign fill_level_o       = {1'b0, wr_ptr_q};
  assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_pcm_pingpong_buffer.sv
// tb_pcm_pingpong_buffer: randomized bench for pcm_pingpong_buffer against a latency-level
// reference model (per-bank sample arrays plus announce/stream timing rules).
// Define OVERFLOW_CNT_EN to also check overflow_count_o.
module tb_pcm_pingpong_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 24;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DATA_W-1:0]      sample;
  logic                   sample_valid;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic                   buf_ready;
  logic [$clog2(DEPTH):0] fill_level;
  logic                   overflow;
  logic                   clear_overflow;
`ifdef OVERFLOW_CNT_EN
  logic [15:0]            overflow_count;
`endif

  always #5 clk = ~clk;

  pcm_pingpong_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .sample_i           (sample),
    .sample_valid_i     (sample_valid),
    .ram_read_data_o    (rd_data),
    .ram_read_valid_o   (rd_valid),
    .ram_read_ready_i   (rd_ready),
    .ram_buffer_ready_o (buf_ready),
    .fill_level_o       (fill_level),
    .overflow_o         (overflow),
`ifdef OVERFLOW_CNT_EN
    .overflow_count_o   (overflow_count),
`endif
    .clear_overflow_i   (clear_overflow)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model: what each bank holds, who owns it, and when the reader is free again
  logic [DATA_W-1:0] bank_mem [2][DEPTH];
  int                bank_cnt [2];
  int                m_wr_bank, m_rd_bank, m_idx, m_last_rel;
  bit                m_streaming, m_ovf, m_after_rst;
`ifdef OVERFLOW_CNT_EN
  int unsigned       m_cnt;
`endif

  function automatic void model_reset();
    bank_cnt[0] = 0;
    bank_cnt[1] = 0;
    m_wr_bank   = 0;
    m_rd_bank   = 0;
    m_idx       = 0;
    m_last_rel  = -100;
    m_streaming = 1'b0;
    m_ovf       = 1'b0;
    m_after_rst = 1'b1;
`ifdef OVERFLOW_CNT_EN
    m_cnt       = 0;
`endif
  endfunction

  // Check the current cycle's outputs, apply inputs for the next edge, advance the model
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit rdy, input bit clr,
                      input bit r);
    bit e_pulse, drop;
    // Reader announces once a bank is full, no earlier than two cycles after the last release
    e_pulse = !m_streaming && (bank_cnt[m_rd_bank] == DEPTH) && (cyc >= m_last_rel + 2);
    check("valid", 32'(rd_valid), 32'(m_streaming));
    check("pulse", 32'(buf_ready), 32'(e_pulse));
    if (m_streaming) check("data", 32'(rd_data), 32'(bank_mem[m_rd_bank][m_idx]));
    if (m_after_rst) check("data_after_reset", 32'(rd_data), 32'd0);
    check("fill_level", 32'(fill_level), 32'(bank_cnt[m_wr_bank] % DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef OVERFLOW_CNT_EN
    check("overflow_count", 32'(overflow_count), m_cnt);
`endif
    sample_valid   = v;
    sample         = d;
    rd_ready       = rdy;
    clear_overflow = clr;
    rst            = r;
    m_after_rst    = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      drop = 1'b0;
      if (v) begin
        if (bank_cnt[m_wr_bank] < DEPTH) begin
          bank_mem[m_wr_bank][bank_cnt[m_wr_bank]] = d;
          bank_cnt[m_wr_bank]++;
          if (bank_cnt[m_wr_bank] == DEPTH) m_wr_bank ^= 1;
        end else begin
          drop = 1'b1;
        end
      end
      if (clr) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
`ifdef OVERFLOW_CNT_EN
      if (clr) m_cnt = 0;
      if (drop && m_cnt < 32'hFFFF) m_cnt++;
`endif
      if (e_pulse) begin
        m_streaming = 1'b1;
        m_idx       = 0;
      end else if (m_streaming && rdy) begin
        m_idx++;
        if (m_idx == DEPTH) begin
          bank_cnt[m_rd_bank] = 0;
          m_rd_bank  ^= 1;
          m_streaming = 1'b0;
          m_last_rel  = cyc;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] specials [3];
    specials[0] = 24'h800000;
    specials[1] = 24'hFFFFFF;
    specials[2] = 24'h7FFFFF;

    rst            = 1'b1;
    sample         = '0;
    sample_valid   = 1'b0;
    rd_ready       = 1'b0;
    clear_overflow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();

    // Fill one bank with 1..16, consumer always ready
    for (int i = 1; i <= 16; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
    idle(24, 1'b1);

    // Extreme signed values must pass bit-exact
    for (int i = 0; i < 16; i++) step(1'b1, (i < 3) ? specials[i] : DATA_W'($urandom), 1'b1,
                                      1'b0, 1'b0);
    idle(24, 1'b1);

    // Backpressure: ready alternates every cycle
    for (int i = 0; i < 16; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 44; i++) step(1'b0, '0, (i % 2) == 0, 1'b0, 1'b0);

    // Overflow: consumer stalled, 40 strobes fill both banks and drop 8
    for (int i = 0; i < 40; i++) step(1'b1, DATA_W'(100 + i), 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(50, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Ping-pong: a strobe every 4 cycles with ready high never drops
    for (int i = 0; i < 300; i++) step((i % 4) == 0, DATA_W'($urandom), 1'b1, 1'b0, 1'b0);
    idle(10, 1'b1);

    // Reset after 5 of 16 transfers, then a fresh bank
    for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(200 + i), 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(300 + i), 1'b1, 1'b0, 1'b0);
    idle(24, 1'b1);

    // Random traffic: bursty strobes, random ready, occasional clear and reset
    for (int i = 0; i < 4000; i++) begin
      bit v, rdy, clr, r;
      logic [DATA_W-1:0] d;
      v   = ($urandom_range(0, 2) == 0);
      rdy = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 49) == 0);
      r   = ($urandom_range(0, 1499) == 0);
      d   = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 2)] : DATA_W'($urandom);
      step(v, d, rdy, clr, r);
    end
    idle(60, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
